// File: rtl/lights_sequencer.sv
// Control block for the holiday-lights LED shifter: button debounce, step-tick
// prescaler and the LOAD/RUN/HOLD show sequencer driving the downstream rotator.
module lights_sequencer #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RUN_STEPS  = 15,
  parameter int HOLD_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button,
  input  logic [2:0]  switch,
  input  logic        dir,
  output logic        led_load,
  output logic [15:0] led_pattern,
  output logic        shift_en,
  output logic        shift_dir,
  output logic        busy,
  output logic [1:0]  state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(RUN_STEPS) + 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2;
  logic          btn_db, btn_db_q;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pre_cnt;
  logic [SW-1:0] step_cnt, step_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          press, tick;
  logic [15:0]   seed;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Count consecutive synced samples that disagree with the accepted level;
  // the level flips once DEB_CYCLES of them arrive in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (sync2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        btn_db  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_q;
  assign tick  = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (state == IDLE || state == LOAD || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: if (press) state_nxt = LOAD;
      LOAD: begin
        state_nxt = RUN;
        step_nxt  = '0;
        hold_nxt  = '0;
      end
      RUN: begin
        if (press) begin
          state_nxt = IDLE;
        end else if (tick) begin
          step_nxt = step_cnt + SW'(1);
          if (step_cnt == SW'(RUN_STEPS - 1)) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (press) begin
          state_nxt = IDLE;
        end else if (tick) begin
          hold_nxt = hold_cnt + HW'(1);
          if (hold_cnt == HW'(HOLD_TICKS - 1)) state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Low (switch+1) bits set.
  assign seed = 16'hFFFF >> (4'd15 - {1'b0, switch});

  // Seed and direction are captured on the edge that enters LOAD, so they are
  // stable for the whole LOAD cycle and the show that follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_pattern <= 16'h0000;
      shift_dir   <= 1'b0;
    end else if (state != LOAD && state_nxt == LOAD) begin
      led_pattern <= seed;
      shift_dir   <= dir;
    end
  end

  assign led_load = (state == LOAD);
  assign shift_en = (state == RUN) && tick && !press;
  assign busy     = (state != IDLE);
  assign state_o  = state;

endmodule

// File: tb/tb_lights_sequencer.sv
// Directed bench for lights_sequencer: expected load/shift pulses are queued by
// the stimulus and matched by an independent monitor.
module tb_lights_sequencer;
  localparam int TD = 4, DB = 3, RS = 3, HT = 2;

  logic        clk = 1'b0, rst_n = 1'b0, button = 1'b0, dir = 1'b0;
  logic [2:0]  switch = 3'd0;
  logic        led_load, shift_en, shift_dir, busy;
  logic [15:0] led_pattern;
  logic [1:0]  state_o;

  typedef struct {
    int          cyc;
    bit          shift;
    logic [15:0] pat;
    logic        dir;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0, vectors = 0, miscompares = 0;
  int  t, l1, l2, l3;

  lights_sequencer #(.TICK_DIV(TD), .DEB_CYCLES(DB), .RUN_STEPS(RS), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .switch(switch), .dir(dir),
    .led_load(led_load), .led_pattern(led_pattern), .shift_en(shift_en),
    .shift_dir(shift_dir), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_load(input int c, input logic [15:0] p, input logic d);
    ev_t e;
    e.cyc = c; e.shift = 1'b0; e.pat = p; e.dir = d;
    exp_q.push_back(e);
  endtask

  task automatic push_shift(input int c, input logic d);
    ev_t e;
    e.cyc = c; e.shift = 1'b1; e.pat = 16'h0; e.dir = d;
    exp_q.push_back(e);
  endtask

  // Advance to just after the posedge that starts cycle c.
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_at(input int c, input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    at(c);
    @(negedge clk);
    case (act_sel)
      0: check(name, {30'd0, state_o}, exp);
      1: check(name, {31'd0, shift_en}, exp);
      default: check(name, {29'd0, busy, state_o}, exp);
    endcase
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (led_load || shift_en) begin
      if (led_load && shift_en) check("load_shift_overlap", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse at cycle %0d: load=%b shift=%b, none expected",
                 cyc, led_load, shift_en);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, shift_en}, {31'd0, e.shift});
        check("pulse_cycle", cyc, e.cyc);
        if (!e.shift) check("led_pattern", {16'd0, led_pattern}, {16'd0, e.pat});
        check("shift_dir", {31'd0, shift_dir}, {31'd0, e.dir});
        check("pulse_state", {30'd0, state_o}, e.shift ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a toggling button.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_outputs", {10'd0, led_load, led_pattern, shift_en, shift_dir, busy, state_o}, 32'd0);
      button = ~button;
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    button = 1'b0;
    check_at(cyc + 8, "idle_after_reset", 2, 32'd0);

    // Two-cycle glitch must not start a show.
    at(cyc + 1);
    t = cyc;
    button = 1'b1;
    at(t + 2);
    button = 1'b0;
    check_at(t + 15, "glitch_idle", 0, 32'd0);

    // Show 1: seed 0007, dir 1; reload picks up switch=7, dir=0.
    switch = 3'b010;
    dir    = 1'b1;
    at(cyc + 1);
    t  = cyc;
    button = 1'b1;
    l1 = t + 6;
    push_load(l1, 16'h0007, 1'b1);
    push_shift(l1 + 4, 1'b1);
    push_shift(l1 + 8, 1'b1);
    push_shift(l1 + 12, 1'b1);
    push_load(l1 + 21, 16'h00FF, 1'b0);
    check_at(l1 + 1, "state_run", 0, 32'd2);
    at(t + 10);
    button = 1'b0;
    at(l1 + 10);
    switch = 3'b111;
    dir    = 1'b0;
    check_at(l1 + 13, "state_hold", 0, 32'd3);
    check_at(l1 + 20, "state_hold_end", 0, 32'd3);
    check_at(l1 + 21, "state_reload", 0, 32'd1);

    // Show 2: press lands on the 2nd RUN tick and wins over the shift.
    l2 = l1 + 21;
    push_shift(l2 + 4, 1'b0);
    at(l2 + 3);
    button = 1'b1;
    check_at(l2 + 8, "stop_no_shift", 1, 32'd0);
    at(l2 + 9);
    button = 1'b0;
    @(negedge clk);
    check("stop_idle", {29'd0, busy, state_o}, 32'd0);

    // Show 3: seed 0001; a press during the reload LOAD is ignored.
    switch = 3'b000;
    dir    = 1'b0;
    at(l2 + 30);
    t  = cyc;
    button = 1'b1;
    l3 = t + 6;
    push_load(l3, 16'h0001, 1'b0);
    push_shift(l3 + 4, 1'b0);
    push_shift(l3 + 8, 1'b0);
    push_shift(l3 + 12, 1'b0);
    push_load(l3 + 21, 16'h003F, 1'b1);
    push_shift(l3 + 25, 1'b1);
    at(t + 8);
    button = 1'b0;
    at(l3 + 10);
    switch = 3'b101;
    dir    = 1'b1;
    at(l3 + 16);
    button = 1'b1;
    check_at(l3 + 22, "press_in_load_ignored", 0, 32'd2);
    at(l3 + 24);
    button = 1'b0;

    // Reset between shifts clears outputs at once; nothing follows release.
    at(l3 + 27);
    rst_n = 1'b0;
    #1;
    check("async_reset", {10'd0, led_load, led_pattern, shift_en, shift_dir, busy, state_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_at(cyc + 30, "idle_after_midrun_reset", 2, 32'd0);

    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: %s expected at cycle %0d, not seen",
               e.shift ? "shift_en" : "led_load", e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
